imem_boot_loader: RTL

//  Boot-time sequencer for the instruction memory: accepts a byte stream (valid/ready),

---
 rtl/imem_boot_pkg.sv | 18 +
 rtl/byte_word_packer.sv | 42 ++++
 rtl/imem_boot_loader.sv | 111 +++++++++++
 3 files changed

// File: rtl/imem_boot_pkg.sv
// rtl/imem_boot_pkg.sv - shared types and sizes for the imem boot loader
package imem_boot_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int DEPTH_DEFAULT  = 16;
    // word_count must represent 0..DEPTH inclusive
    localparam int WC_W           = $clog2(DEPTH_DEFAULT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - places boot bytes little-endian into a 32-bit word
module byte_word_packer
    import imem_boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  data,
    output logic [31:0] word_next,
    output logic        word_full
);

    logic [1:0]  idx;
    logic [31:0] word;

    // the word as it will look once the current byte lands in its lane
    always_comb begin
        word_next = word;
        case (idx)
            2'd0:    word_next[7:0]   = data;
            2'd1:    word_next[15:8]  = data;
            2'd2:    word_next[23:16] = data;
            default: word_next[31:24] = data;
        endcase
    end

    // high only on the cycle the last byte of a word is being accepted
    assign word_full = load && (idx == 2'(BYTES_PER_WORD - 1));

    // byte index and partial word; index wraps to 0 after the 4th byte
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            idx  <= 2'd0;
            word <= 32'd0;
        end else if (load) begin
            idx  <= idx + 2'd1;
            word <= word_next;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - loads a length-prefixed byte image into imem, then releases the core
module imem_boot_loader
    import imem_boot_pkg::*;
#(
    parameter int          DEPTH     = DEPTH_DEFAULT,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            boot_en,
    input  logic            byte_valid,
    input  logic [7:0]      byte_data,
    output logic            byte_ready,
    output logic            imem_we,
    output logic [31:0]     imem_addr,
    output logic [31:0]     imem_wdata,
    output logic            cpu_rst,
    output logic            load_done,
    output logic            load_err,
    output logic [WC_W-1:0] word_count
);

    state_t          state;
    state_t          state_next;
    logic            byte_fire;
    logic            hdr_ok;
    logic            pack_load;
    logic            pack_clear;
    logic            word_full;
    logic [31:0]     word_next;
    logic [WC_W-1:0] word_total;
    logic [WC_W-1:0] count_inc;
    logic            start_req;

    assign byte_fire  = byte_valid && byte_ready;
    // N outside 1..DEPTH is rejected, which also keeps the address in range
    assign hdr_ok     = (byte_data != 8'd0) && ({24'd0, byte_data} <= 32'(DEPTH));
    assign pack_load  = byte_fire && (state == ST_DATA);
    assign pack_clear = (state != ST_DATA) && (state != ST_WRITE);
    assign count_inc  = word_count + WC_W'(1);
    assign start_req  = boot_en &&
                        ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));

    byte_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (pack_clear),
        .load      (pack_load),
        .data      (byte_data),
        .word_next (word_next),
        .word_full (word_full)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state: boot_en only matters when no load is in flight
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (boot_en) state_next = ST_HDR;
            ST_HDR:   if (byte_fire) state_next = hdr_ok ? ST_DATA : ST_ERR;
            ST_DATA:  if (word_full) state_next = ST_WRITE;
            ST_WRITE: state_next = (count_inc == word_total) ? ST_DONE : ST_DATA;
            ST_DONE:  if (boot_en) state_next = ST_HDR;
            ST_ERR:   if (boot_en) state_next = ST_HDR;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Moore outputs; the core is released only in DONE
    always_comb begin
        byte_ready = (state == ST_HDR) || (state == ST_DATA);
        imem_we    = (state == ST_WRITE);
        cpu_rst    = (state == ST_DONE);
        load_done  = (state == ST_DONE);
        load_err   = (state == ST_ERR);
    end

    // image length, word counter and the held write address/data
    always_ff @(posedge clk) begin
        if (!rst) begin
            word_total <= '0;
            word_count <= '0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= 32'd0;
        end else begin
            if (start_req) begin
                word_count <= '0;
            end
            if ((state == ST_HDR) && byte_fire) begin
                word_total <= byte_data[WC_W-1:0];
            end
            if (word_full) begin
                imem_addr  <= BASE_ADDR + (32'(word_count) << 2);
                imem_wdata <= word_next;
            end
            if (state == ST_WRITE) begin
                word_count <= count_inc;
            end
        end
    end

endmodule
